// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: round-robin between ALU (req0) and load unit (req1) feeding a
// 2-entry write queue that drains into the register file port, with a forwarding lookup.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int QDEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_dest,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_dest,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  rf_wrt_stall,
    output logic                  rg_wrt_en,
    output logic [ADDR_WIDTH-1:0] rg_wrt_dest,
    output logic [DATA_WIDTH-1:0] rg_wrt_data,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [DATA_WIDTH-1:0] lookup_data,
    output logic [1:0]            q_count
);

    // Entry 0 is always the head (oldest); entry 1 is the younger one.
    logic [ADDR_WIDTH-1:0] dest_reg  [0:QDEPTH-1];
    logic [DATA_WIDTH-1:0] data_reg  [0:QDEPTH-1];
    logic [ADDR_WIDTH-1:0] dest_next [0:QDEPTH-1];
    logic [DATA_WIDTH-1:0] data_next [0:QDEPTH-1];
    logic [1:0]            count_reg;
    logic [1:0]            count_next;
    logic                  rr_reg;
    logic                  rr_next;

    logic                  pop;
    logic                  space;
    logic                  grant0;
    logic                  grant1;
    logic                  push;
    logic [ADDR_WIDTH-1:0] push_dest;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            wr_idx;
    logic [QDEPTH-1:0]     ent_valid;
    logic [QDEPTH-1:0]     match;

    assign pop    = (count_reg != 2'd0) && !rf_wrt_stall;
    assign space  = (count_reg < 2'd2) || pop;
    assign grant0 = space && req0_valid && (!req1_valid || !rr_reg);
    assign grant1 = space && req1_valid && (!req0_valid || rr_reg);

    assign push_dest = grant1 ? req1_dest : req0_dest;
    assign push_data = grant1 ? req1_data : req0_data;
    // x0 writes complete the handshake but are silently dropped.
    assign push      = (grant0 || grant1) && (push_dest != '0);

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rg_wrt_en   = pop;
    assign rg_wrt_dest = pop ? dest_reg[0] : '0;
    assign rg_wrt_data = pop ? data_reg[0] : '0;
    assign q_count     = count_reg;

    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            assign ent_valid[gi] = count_reg > 2'(gi);
            assign match[gi]     = ent_valid[gi] && (dest_reg[gi] == lookup_addr);
        end
    endgenerate

    assign lookup_hit  = (lookup_addr != '0) && (|match);
    assign lookup_data = !lookup_hit ? '0 :
                         match[1]    ? data_reg[1] : data_reg[0];

    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            dest_next[i] = dest_reg[i];
            data_next[i] = data_reg[i];
        end
        wr_idx = count_reg - {1'b0, pop};
        if (pop) begin
            dest_next[0] = dest_reg[1];
            data_next[0] = data_reg[1];
        end
        // New entry lands just behind whatever remains after this cycle's pop.
        if (push) begin
            dest_next[wr_idx[0]] = push_dest;
            data_next[wr_idx[0]] = push_data;
        end
        count_next = count_reg + {1'b0, push} - {1'b0, pop};
        rr_next    = rr_reg;
        if (grant0) rr_next = 1'b1;
        if (grant1) rr_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 2'd0;
            rr_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            rr_reg    <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            dest_reg[i] <= dest_next[i];
            data_reg[i] <= data_next[i];
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus queues expected register-file writes,
// a negedge monitor pops and compares every rg_wrt_en cycle.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_dest, req1_dest;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_wrt_stall;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic [4:0]  lookup_addr;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic [1:0]  q_count;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    rf_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_wrt_stall(rf_wrt_stall),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rg_wrt_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got dest=%0d data=%h expected none", rg_wrt_dest, rg_wrt_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_dest", {27'd0, rg_wrt_dest}, {27'd0, e[36:32]});
                check("wr_data", rg_wrt_data, e[31:0]);
            end
        end
    end

    task automatic set_req(input logic v0, input logic [4:0] d0, input logic [31:0] x0,
                           input logic v1, input logic [4:0] d1, input logic [31:0] x1);
        req0_valid = v0; req0_dest = d0; req0_data = x0;
        req1_valid = v1; req1_dest = d1; req1_data = x1;
    endtask

    task automatic idle();
        set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rf_wrt_stall = 1'b0;
        lookup_addr = 5'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wr_en", {31'd0, rg_wrt_en}, 32'd0);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check("rst_hit", {31'd0, lookup_hit}, 32'd0);
        check("rst_count", {30'd0, q_count}, 32'd0);
        check("rst_wr_dest", {27'd0, rg_wrt_dest}, 32'd0);
        next_cycle();

        // Single write
        set_req(1'b1, 5'd3, 32'hA5A5_0001, 1'b0, 5'd0, 32'd0);
        exp_q.push_back({5'd3, 32'hA5A5_0001});
        @(negedge clk);
        check("single_ready0", {31'd0, req0_ready}, 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("single_wr_en_c1", {31'd0, rg_wrt_en}, 32'd1);
        check("single_count_c1", {30'd0, q_count}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("single_wr_en_c2", {31'd0, rg_wrt_en}, 32'd0);
        check("single_count_c2", {30'd0, q_count}, 32'd0);
        next_cycle();

        // Contention: grants alternate 0,1,0,1; writes in grant order
        do_reset();
        begin
            logic [4:0] d0_tab [4] = '{5'd1, 5'd3, 5'd3, 5'd5};
            logic [4:0] d1_tab [4] = '{5'd2, 5'd2, 5'd4, 5'd4};
            logic       g_tab  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
            logic [1:0] c_tab  [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
            for (int i = 0; i < 4; i++) begin
                set_req(1'b1, d0_tab[i], 32'hC0DE_0000 | 32'(d0_tab[i]),
                        1'b1, d1_tab[i], 32'hD00D_0000 | 32'(d1_tab[i]));
                if (g_tab[i]) exp_q.push_back({d1_tab[i], 32'hD00D_0000 | 32'(d1_tab[i])});
                else          exp_q.push_back({d0_tab[i], 32'hC0DE_0000 | 32'(d0_tab[i])});
                @(negedge clk);
                check($sformatf("cont_ready0_%0d", i), {31'd0, req0_ready}, {31'd0, !g_tab[i]});
                check($sformatf("cont_ready1_%0d", i), {31'd0, req1_ready}, {31'd0, g_tab[i]});
                check($sformatf("cont_count_%0d", i), {30'd0, q_count}, {30'd0, c_tab[i]});
                next_cycle();
            end
            idle();
            repeat (2) next_cycle();
        end

        // Full queue under stall, then release with push+pop
        do_reset();
        rf_wrt_stall = 1'b1;
        begin
            logic [4:0] d_tab  [5] = '{5'd5, 5'd6, 5'd7, 5'd7, 5'd7};
            logic       r_tab  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            logic [1:0] c_tab  [5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
            logic       s_tab  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++) begin
                rf_wrt_stall = s_tab[i];
                set_req(1'b0, 5'd0, 32'd0, 1'b1, d_tab[i], 32'h0000_0F00 | 32'(d_tab[i]));
                if (r_tab[i]) exp_q.push_back({d_tab[i], 32'h0000_0F00 | 32'(d_tab[i])});
                @(negedge clk);
                check($sformatf("full_ready1_%0d", i), {31'd0, req1_ready}, {31'd0, r_tab[i]});
                check($sformatf("full_count_%0d", i), {30'd0, q_count}, {30'd0, c_tab[i]});
                check($sformatf("full_wr_en_%0d", i), {31'd0, rg_wrt_en}, {31'd0, !s_tab[i]});
                next_cycle();
            end
            idle();
            @(negedge clk);
            check("full_count_drain1", {30'd0, q_count}, 32'd2);
            next_cycle();
            @(negedge clk);
            check("full_count_drain2", {30'd0, q_count}, 32'd1);
            next_cycle();
            @(negedge clk);
            check("full_count_drain3", {30'd0, q_count}, 32'd0);
            next_cycle();
        end

        // x0 drop: handshake completes, nothing queued, rr toggles
        do_reset();
        set_req(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("x0_ready0", {31'd0, req0_ready}, 32'd1);
        next_cycle();
        set_req(1'b1, 5'd20, 32'h0000_0020, 1'b1, 5'd21, 32'h0000_0021);
        exp_q.push_back({5'd21, 32'h0000_0021});
        @(negedge clk);
        check("x0_count", {30'd0, q_count}, 32'd0);
        check("x0_wr_en", {31'd0, rg_wrt_en}, 32'd0);
        check("x0_tie_ready0", {31'd0, req0_ready}, 32'd0);
        check("x0_tie_ready1", {31'd0, req1_ready}, 32'd1);
        next_cycle();
        idle();
        repeat (2) next_cycle();

        // Forwarding: youngest match wins, in-flight push invisible, x0 never hits
        do_reset();
        rf_wrt_stall = 1'b1;
        lookup_addr = 5'd9;
        set_req(1'b1, 5'd9, 32'h0000_0011, 1'b0, 5'd0, 32'd0);
        exp_q.push_back({5'd9, 32'h0000_0011});
        @(negedge clk);
        check("fwd_enq_invisible", {31'd0, lookup_hit}, 32'd0);
        next_cycle();
        set_req(1'b1, 5'd9, 32'h0000_0022, 1'b0, 5'd0, 32'd0);
        exp_q.push_back({5'd9, 32'h0000_0022});
        @(negedge clk);
        check("fwd_one_hit", {31'd0, lookup_hit}, 32'd1);
        check("fwd_one_data", lookup_data, 32'h0000_0011);
        next_cycle();
        idle();
        @(negedge clk);
        check("fwd_hit", {31'd0, lookup_hit}, 32'd1);
        check("fwd_data", lookup_data, 32'h0000_0022);
        lookup_addr = 5'd0;
        #1;
        check("fwd_x0_hit", {31'd0, lookup_hit}, 32'd0);
        check("fwd_x0_data", lookup_data, 32'd0);
        lookup_addr = 5'd5;
        #1;
        check("fwd_miss", {31'd0, lookup_hit}, 32'd0);
        next_cycle();
        rf_wrt_stall = 1'b0;
        lookup_addr = 5'd9;
        @(negedge clk);
        check("fwd_pop_hit", {31'd0, lookup_hit}, 32'd1);
        check("fwd_pop_data", lookup_data, 32'h0000_0022);
        next_cycle();
        @(negedge clk);
        check("fwd_last_hit", {31'd0, lookup_hit}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("fwd_empty_hit", {31'd0, lookup_hit}, 32'd0);
        next_cycle();

        // Reset mid-operation discards queued writes and restores rr=0
        do_reset();
        rf_wrt_stall = 1'b1;
        set_req(1'b1, 5'd12, 32'h0000_0012, 1'b0, 5'd0, 32'd0);
        next_cycle();
        set_req(1'b1, 5'd13, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("mid_count_full", {30'd0, q_count}, 32'd2);
        next_cycle();
        set_req(1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        rst = 1'b1;
        idle();
        next_cycle();
        rst = 1'b0;
        rf_wrt_stall = 1'b0;
        @(negedge clk);
        check("mid_count_rst", {30'd0, q_count}, 32'd0);
        check("mid_wr_en", {31'd0, rg_wrt_en}, 32'd0);
        next_cycle();
        set_req(1'b1, 5'd14, 32'h0000_0014, 1'b1, 5'd15, 32'h0000_0015);
        exp_q.push_back({5'd14, 32'h0000_0014});
        @(negedge clk);
        check("mid_tie_ready0", {31'd0, req0_ready}, 32'd1);
        check("mid_tie_ready1", {31'd0, req1_ready}, 32'd0);
        next_cycle();
        idle();
        repeat (4) next_cycle();

        check("all_writes_seen", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
